// File: rtl/hs_expect_pkg.sv
// Shared types for the handshake expect monitor: the property mode, the
// per-channel attempt state, and the sizing helper for the delay counter.
package hs_expect_pkg;

  typedef enum logic [1:0] {
    RANGE = 2'd0,
    SEQ   = 2'd1,
    IMPL  = 2'd2,
    RSVD  = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    FIRST     = 2'd1,
    WAIT_ACK  = 2'd2,
    WAIT_DONE = 2'd3
  } state_e;

  function automatic int dly_cnt_width(input int max_dly);
    return $clog2(max_dly + 1);
  endfunction

endpackage

// File: rtl/hs_expect_chan.sv
// One monitor channel: a single armed evaluation attempt of the selected
// req/ack/done property, ending in a registered one-cycle verdict.
module hs_expect_chan
  import hs_expect_pkg::*;
#(
  parameter int MIN_DLY = 1,
  parameter int MAX_DLY = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       arm,
  input  logic [1:0] mode,
  input  logic       req,
  input  logic       ack,
  input  logic       done,
  output logic       busy,
  output logic       pass,
  output logic       fail,
  output logic       vacuous,
  output logic       arm_err
);

  localparam int DW = dly_cnt_width(MAX_DLY);
  localparam logic [DW-1:0] MIN_C = DW'(MIN_DLY);
  localparam logic [DW-1:0] MAX_C = DW'(MAX_DLY);

  state_e        state, state_nxt;
  mode_e         mode_q, mode_nxt;
  logic [DW-1:0] cnt, cnt_nxt, cnt_inc;
  logic          hit;
  logic          pass_nxt, fail_nxt, vac_nxt, err_nxt;

  // The counter value after this edge is the delay being judged, so the
  // window compare uses the incremented count.
  assign cnt_inc = cnt + DW'(1);
  assign hit     = (mode_q == IMPL) ? (ack && !done) : ack;

  always_comb begin
    state_nxt = state;
    mode_nxt  = mode_q;
    cnt_nxt   = cnt;
    pass_nxt  = 1'b0;
    fail_nxt  = 1'b0;
    vac_nxt   = 1'b0;
    err_nxt   = 1'b0;
    case (state)
      IDLE: begin
        if (arm) begin
          if (mode_e'(mode) == RSVD) begin
            err_nxt = 1'b1;
          end else begin
            mode_nxt  = mode_e'(mode);
            state_nxt = FIRST;
          end
        end
      end
      FIRST: begin
        if (!req) begin
          if (mode_q == IMPL) begin
            pass_nxt = 1'b1;
            vac_nxt  = 1'b1;
          end else begin
            fail_nxt = 1'b1;
          end
          state_nxt = IDLE;
        end else begin
          cnt_nxt   = '0;
          state_nxt = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        cnt_nxt = cnt_inc;
        if (mode_q == SEQ) begin
          if (ack) begin
            state_nxt = WAIT_DONE;
          end else begin
            fail_nxt  = 1'b1;
            state_nxt = IDLE;
          end
        end else if (hit && (cnt_inc >= MIN_C)) begin
          pass_nxt  = 1'b1;
          state_nxt = IDLE;
        end else if (cnt_inc == MAX_C) begin
          fail_nxt  = 1'b1;
          state_nxt = IDLE;
        end
      end
      WAIT_DONE: begin
        pass_nxt  = done;
        fail_nxt  = !done;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // A re-arm while an attempt runs is flagged but never alters the attempt.
    if (arm && (state != IDLE)) begin
      err_nxt = 1'b1;
    end
  end

  // busy lags the state by one edge so it stays high through the verdict cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      mode_q  <= RANGE;
      cnt     <= '0;
      busy    <= 1'b0;
      pass    <= 1'b0;
      fail    <= 1'b0;
      vacuous <= 1'b0;
      arm_err <= 1'b0;
    end else begin
      state   <= state_nxt;
      mode_q  <= mode_nxt;
      cnt     <= cnt_nxt;
      busy    <= (state != IDLE);
      pass    <= pass_nxt;
      fail    <= fail_nxt;
      vacuous <= vac_nxt;
      arm_err <= err_nxt;
    end
  end

endmodule

// File: rtl/hs_expect_monitor.sv
// Multi-channel handshake expect monitor: NCH independent channels plus
// saturating aggregate pass/fail totals for a status block.
module hs_expect_monitor
  import hs_expect_pkg::*;
#(
  parameter int NCH     = 4,
  parameter int MIN_DLY = 1,
  parameter int MAX_DLY = 5,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NCH-1:0]   arm,
  input  logic [2*NCH-1:0] mode,
  input  logic [NCH-1:0]   req,
  input  logic [NCH-1:0]   ack,
  input  logic [NCH-1:0]   done,
  input  logic             clr_cnt,
  output logic [NCH-1:0]   busy,
  output logic [NCH-1:0]   pass,
  output logic [NCH-1:0]   fail,
  output logic [NCH-1:0]   vacuous,
  output logic [NCH-1:0]   arm_err,
  output logic [CNT_W-1:0] pass_total,
  output logic [CNT_W-1:0] fail_total
);

  localparam int PW = $clog2(NCH + 1);
  localparam int SW = CNT_W + PW;

  if (NCH < 1 || NCH > 32 || MIN_DLY < 1 || MIN_DLY > MAX_DLY || MAX_DLY > 255) begin : g_bad_params
    $error("hs_expect_monitor: illegal NCH/MIN_DLY/MAX_DLY");
  end

  for (genvar i = 0; i < NCH; i++) begin : g_chan
    hs_expect_chan #(
      .MIN_DLY(MIN_DLY),
      .MAX_DLY(MAX_DLY)
    ) u_chan (
      .clk     (clk),
      .rst_n   (rst_n),
      .arm     (arm[i]),
      .mode    (mode[2*i +: 2]),
      .req     (req[i]),
      .ack     (ack[i]),
      .done    (done[i]),
      .busy    (busy[i]),
      .pass    (pass[i]),
      .fail    (fail[i]),
      .vacuous (vacuous[i]),
      .arm_err (arm_err[i])
    );
  end

  function automatic logic [PW-1:0] popcnt(input logic [NCH-1:0] v);
    logic [PW-1:0] n;
    n = '0;
    for (int k = 0; k < NCH; k++) begin
      n = n + PW'(v[k]);
    end
    return n;
  endfunction

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] total,
                                               input logic [PW-1:0]    inc);
    logic [SW-1:0] sum;
    sum = SW'(total) + SW'(inc);
    return (sum > SW'({CNT_W{1'b1}})) ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
  endfunction

  // Totals consume the registered verdict pulses; a clear drops them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pass_total <= '0;
      fail_total <= '0;
    end else if (clr_cnt) begin
      pass_total <= '0;
      fail_total <= '0;
    end else begin
      pass_total <= sat_add(pass_total, popcnt(pass));
      fail_total <= sat_add(fail_total, popcnt(fail));
    end
  end

endmodule

// File: tb/tb_hs_expect_monitor.sv
// Directed bench for hs_expect_monitor: 4 channels, delay window 1..5,
// 4-bit totals so saturation is reachable.
module tb_hs_expect_monitor;

  logic       clk;
  logic       rst_n;
  logic [3:0] arm, req, ack, done;
  logic [7:0] mode;
  logic       clr_cnt;
  logic [3:0] busy, pass, fail, vacuous, arm_err;
  logic [3:0] pass_total, fail_total;

  int total_cnt;
  int bad_cnt;
  logic [3:0] seen;

  hs_expect_monitor #(
    .NCH(4), .MIN_DLY(1), .MAX_DLY(5), .CNT_W(4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .arm        (arm),
    .mode       (mode),
    .req        (req),
    .ack        (ack),
    .done       (done),
    .clr_cnt    (clr_cnt),
    .busy       (busy),
    .pass       (pass),
    .fail       (fail),
    .vacuous    (vacuous),
    .arm_err    (arm_err),
    .pass_total (pass_total),
    .fail_total (fail_total)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs, let the edge sample them, then settle.
  task automatic applyStimulus(input logic [3:0] a, input logic [3:0] r,
                               input logic [3:0] k, input logic [3:0] d);
    arm  = a;
    req  = r;
    ack  = k;
    done = d;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    total_cnt++;
    if (obs !== exp) begin
      bad_cnt++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    total_cnt = 0;
    bad_cnt   = 0;
    rst_n     = 1'b0;
    clr_cnt   = 1'b0;
    mode      = 8'h00;
    arm = '0; req = '0; ack = '0; done = '0;
    applyStimulus(4'h0, 4'h0, 4'h0, 4'h0);
    applyStimulus(4'h0, 4'h0, 4'h0, 4'h0);
    checkOutput("rst_busy", busy, 4'h0);
    checkOutput("rst_pass", pass, 4'h0);
    checkOutput("rst_fail", fail, 4'h0);
    checkOutput("rst_ptot", pass_total, 4'd0);
    checkOutput("rst_ftot", fail_total, 4'd0);
    rst_n = 1'b1;
    applyStimulus(4'h0, 4'h0, 4'h0, 4'h0);

    // RANGE: ack at E3 passes
    mode = 8'h00;
    applyStimulus(4'h1, 4'h0, 4'h0, 4'h0);
    checkOutput("rng_err0", arm_err, 4'h0);
    applyStimulus(4'h0, 4'h1, 4'h0, 4'h0);
    checkOutput("rng_busy_e0", busy, 4'h1);
    checkOutput("rng_pass_e0", pass, 4'h0);
    applyStimulus(4'h0, 4'h0, 4'h0, 4'h0);
    applyStimulus(4'h0, 4'h0, 4'h0, 4'h0);
    applyStimulus(4'h0, 4'h0, 4'h1, 4'h0);
    checkOutput("rng_pass_e3", pass, 4'h1);
    checkOutput("rng_busy_e3", busy, 4'h1);
    applyStimulus(4'h0, 4'h0, 4'h0, 4'h0);
    checkOutput("rng_pass_off", pass, 4'h0);
    checkOutput("rng_ptot", pass_total, 4'd1);
    checkOutput("rng_busy_off", busy, 4'h0);

    // RANGE: ack only at E0 is ignored, timeout at E5
    applyStimulus(4'h1, 4'h0, 4'h0, 4'h0);
    applyStimulus(4'h0, 4'h1, 4'h1, 4'h0);
    for (int i = 0; i < 4; i++) applyStimulus(4'h0, 4'h0, 4'h0, 4'h0);
    checkOutput("rng_fail_e4", fail, 4'h0);
    applyStimulus(4'h0, 4'h0, 4'h0, 4'h0);
    checkOutput("rng_fail_e5", fail, 4'h1);
    applyStimulus(4'h0, 4'h0, 4'h0, 4'h0);
    checkOutput("rng_ftot1", fail_total, 4'd1);

    // RANGE: no req at E0
    applyStimulus(4'h1, 4'h0, 4'h0, 4'h0);
    applyStimulus(4'h0, 4'h0, 4'h0, 4'h0);
    checkOutput("rng_noreq_fail", fail, 4'h1);
    applyStimulus(4'h0, 4'h0, 4'h0, 4'h0);
    checkOutput("rng_ftot2", fail_total, 4'd2);

    // SEQ pass then SEQ missing done
    mode = 8'h01;
    applyStimulus(4'h1, 4'h0, 4'h0, 4'h0);
    applyStimulus(4'h0, 4'h1, 4'h0, 4'h0);
    applyStimulus(4'h0, 4'h0, 4'h1, 4'h0);
    checkOutput("seq_pass_e1", pass, 4'h0);
    applyStimulus(4'h0, 4'h0, 4'h0, 4'h1);
    checkOutput("seq_pass_e2", pass, 4'h1);
    applyStimulus(4'h0, 4'h0, 4'h0, 4'h0);
    checkOutput("seq_ptot", pass_total, 4'd2);
    applyStimulus(4'h1, 4'h0, 4'h0, 4'h0);
    applyStimulus(4'h0, 4'h1, 4'h0, 4'h0);
    applyStimulus(4'h0, 4'h0, 4'h1, 4'h0);
    applyStimulus(4'h0, 4'h0, 4'h0, 4'h0);
    checkOutput("seq_fail_e2", fail, 4'h1);
    applyStimulus(4'h0, 4'h0, 4'h0, 4'h0);
    checkOutput("seq_ftot", fail_total, 4'd3);

    // IMPL: vacuous pass, then ack with done never qualifies
    mode = 8'h02;
    applyStimulus(4'h1, 4'h0, 4'h0, 4'h0);
    applyStimulus(4'h0, 4'h0, 4'h0, 4'h0);
    checkOutput("impl_vac_pass", pass, 4'h1);
    checkOutput("impl_vac", vacuous, 4'h1);
    applyStimulus(4'h0, 4'h0, 4'h0, 4'h0);
    checkOutput("impl_vac_off", vacuous, 4'h0);
    checkOutput("impl_ptot", pass_total, 4'd3);
    applyStimulus(4'h1, 4'h0, 4'h0, 4'h0);
    applyStimulus(4'h0, 4'h1, 4'h0, 4'h0);
    for (int i = 0; i < 4; i++) applyStimulus(4'h0, 4'h0, 4'h1, 4'h1);
    checkOutput("impl_fail_e4", fail, 4'h0);
    applyStimulus(4'h0, 4'h0, 4'h1, 4'h1);
    checkOutput("impl_fail_e5", fail, 4'h1);
    checkOutput("impl_pass_e5", pass, 4'h0);
    applyStimulus(4'h0, 4'h0, 4'h0, 4'h0);
    checkOutput("impl_ftot", fail_total, 4'd4);

    // arm_err: reserved mode on ch1, re-arm of busy ch0
    mode = 8'h0C;
    applyStimulus(4'h3, 4'h0, 4'h0, 4'h0);
    checkOutput("err_rsvd", arm_err, 4'h2);
    applyStimulus(4'h1, 4'h1, 4'h0, 4'h0);
    checkOutput("err_busy", arm_err, 4'h1);
    checkOutput("err_busy_vec", busy, 4'h1);
    applyStimulus(4'h0, 4'h0, 4'h0, 4'h0);
    checkOutput("err_clear", arm_err, 4'h0);
    applyStimulus(4'h0, 4'h0, 4'h1, 4'h0);
    checkOutput("err_attempt_pass", pass, 4'h1);
    applyStimulus(4'h0, 4'h0, 4'h0, 4'h0);
    checkOutput("err_ptot", pass_total, 4'd4);

    // reset in the middle of an attempt
    mode = 8'h00;
    applyStimulus(4'h1, 4'h0, 4'h0, 4'h0);
    applyStimulus(4'h0, 4'h1, 4'h0, 4'h0);
    applyStimulus(4'h0, 4'h0, 4'h0, 4'h0);
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_busy", busy, 4'h0);
    checkOutput("midrst_ptot", pass_total, 4'd0);
    seen = 4'h0;
    applyStimulus(4'h0, 4'h0, 4'h1, 4'h0);
    seen = seen | pass | fail;
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(4'h0, 4'h0, 4'h1, 4'h0);
      seen = seen | pass | fail | busy;
    end
    checkOutput("midrst_no_verdict", seen, 4'h0);

    // saturation with 20 rounds of 4 simultaneous vacuous passes
    mode = 8'hAA;
    for (int i = 0; i < 20; i++) begin
      applyStimulus(4'hF, 4'h0, 4'h0, 4'h0);
      applyStimulus(4'h0, 4'h0, 4'h0, 4'h0);
      if (i == 0) checkOutput("sat_pass_all", pass, 4'hF);
    end
    applyStimulus(4'h0, 4'h0, 4'h0, 4'h0);
    checkOutput("sat_ptot", pass_total, 4'd15);
    checkOutput("sat_ftot", fail_total, 4'd0);

    // clear coincident with a pass pulse
    applyStimulus(4'hF, 4'h0, 4'h0, 4'h0);
    applyStimulus(4'h0, 4'h0, 4'h0, 4'h0);
    checkOutput("clr_pass_pre", pass, 4'hF);
    clr_cnt = 1'b1;
    applyStimulus(4'h0, 4'h0, 4'h0, 4'h0);
    clr_cnt = 1'b0;
    checkOutput("clr_ptot", pass_total, 4'd0);
    applyStimulus(4'h0, 4'h0, 4'h0, 4'h0);
    checkOutput("clr_ptot_after", pass_total, 4'd0);

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule

// File: doc/hs_expect_monitor.md
# hs_expect_monitor

Synthesizable, multi-channel hardware equivalent of a procedural `expect` on request/acknowledge handshakes. Each channel is armed by a pulse and makes exactly one evaluation attempt of a selectable property over `req`/`ack`/`done`. It reports a single-cycle pass, fail or vacuous verdict and keeps saturating aggregate totals. It sits beside bus/handshake interfaces as an on-chip protocol checker and feeds a status/interrupt block.

## Interface
- `NCH`, 4: number of independent channels (1..32)
- `MIN_DLY`, 1: minimum req-to-ack delay in cycles for ranged and implication modes
- `MAX_DLY`, 5: maximum req-to-ack delay; elaboration error unless 1 <= MIN_DLY <= MAX_DLY <= 255
- `CNT_W`, 16: width of aggregate totals
- `clk`  in  1  sole clock; all state changes on rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `arm`  in  NCH  per-channel start pulse
- `mode`  in  2*NCH  per-channel mode, bits [2i+1:2i], sampled only with `arm[i]`
- `req`, `ack`, `done`  in  NCH each  monitored signals
- `clr_cnt`  in  1  synchronous clear of totals
- `busy`  out  NCH  channel attempt in progress
- `pass`, `fail`, `vacuous`  out  NCH each  one-cycle verdict pulses
- `arm_err`  out  NCH  one-cycle pulse: arm rejected
- `pass_total`, `fail_total`  out  CNT_W  saturating counts

## Operation
- Modes:
  - 0 RANGE: req ##[MIN_DLY:MAX_DLY] ack
  - 1 SEQ: req ##1 ack ##1 done
  - 2 IMPL: req |-> ##[MIN_DLY:MAX_DLY] (ack && !done)
  - 3 reserved
- Channel FSM states: IDLE, FIRST, WAIT_ACK, WAIT_DONE.
- IDLE + `arm[i]`: a valid mode latches and the FSM enters FIRST; `busy` rises the next cycle. Mode 3 does not arm and pulses `arm_err`.
- `arm[i]` while busy: ignored, pulses `arm_err`, does not disturb the attempt in progress.
- FIRST samples at edge E0, the first edge after the arming edge:
  - req=0: RANGE/SEQ give `fail`; IMPL gives `pass` plus `vacuous`.
  - req=1: delay counter n=0; SEQ goes to WAIT_ACK (single cycle), others go to WAIT_ACK (ranged).
- WAIT_ACK, at each edge n increments (edge En):
  - RANGE: ack=1 with MIN_DLY <= n <= MAX_DLY gives pass. ack before MIN_DLY is ignored.
  - IMPL: ack && !done inside the window gives pass.
  - RANGE/IMPL: n == MAX_DLY without a match gives fail.
  - SEQ: ack at E1 goes to WAIT_DONE, else fail.
- WAIT_DONE (SEQ only): done at E2 gives pass, else fail.
- After any verdict the FSM returns to IDLE. Re-arming on the verdict cycle is accepted.
- Totals:
  - Each cycle, `pass_total += popcount(pass)` and `fail_total += popcount(fail)`, saturating at 2^CNT_W-1.
  - Vacuous passes count as passes.
  - `clr_cnt` wins over same-cycle increments; those verdicts are not counted.

## Timing
- Reset values: all outputs 0, all FSMs IDLE, totals 0. Reset asserted mid-attempt aborts it silently, with no verdict pulse.
- Verdict outputs are registered at the edge sampling the deciding input and are high for exactly one cycle.
- Arm at edge T gives the earliest verdict at T+1 (E0 decision) and the latest at T+1+MAX_DLY.
- Totals update one cycle after the verdict pulse.
- `busy` is high from T+1 through the verdict cycle, inclusive.
- `arm_err` is registered one cycle after the offending `arm` edge.
- Channels are fully independent; simultaneous verdicts on all channels are legal.

## Structure
- Package `hs_expect_pkg`: mode enum (RANGE, SEQ, IMPL, RSVD), state enum, and a function computing delay counter width $clog2(MAX_DLY+1).
- Sub-module `hs_expect_chan`: one FSM plus delay counter, instantiated NCH times via generate.
- Top level holds the popcount adders and saturating totals.

## Test plan
- RANGE, MIN=1/MAX=5: arm, req=1 at E0, ack at E3 -> `pass[0]` one cycle at E3, `pass_total`=1; repeat with no ack -> `fail[0]` at E5.
- RANGE: req=0 at E0 -> `fail` at E0. Ack only at E0 then none -> fail at E5 (early ack ignored).
- SEQ: req/ack/done at E0/E1/E2 -> pass at E2. Done missing at E2 -> fail at E2.
- IMPL: req=0 -> pass + vacuous at E0. Req=1 with ack=1, done=1 at E1..E5 -> fail at E5.
- Arm during busy and mode=3 arm -> `arm_err` pulse each, attempt unaffected. Reset at E2 mid-attempt -> no verdict, busy=0.
- CNT_W=4: 20 simultaneous 4-channel passes -> `pass_total` saturates at 15. `clr_cnt` coincident with a pass -> 0.
